// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the two-source UART transmit arbiter.
// UART_ARB_PARITY_EN selects an 8E1 frame (11 bits) instead of 8N1 (10 bits).
package uart_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int DATA_BITS = 8;
`ifdef UART_ARB_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-request handshake for the two UART transmit sources.
interface uart_tx_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;

  modport master (output req0_valid, req0_data, req1_valid, req1_data,
                  input  req0_ready, req1_ready);
  modport slave  (input  req0_valid, req0_data, req1_valid, req1_data,
                  output req0_ready, req1_ready);
endinterface

// File: rtl/uart_tx_arbiter_baud.sv
// Bit-period counter: counts 0..DIV-1, tick marks the last cycle of a bit.
module uart_baud_tick #(
  parameter int DIV   = 434,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    if (clear) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART TX line between two byte sources.
// UART_ARB_PARITY_EN adds an even-parity bit between data and stop.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DIV   = 434,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_arbiter_if.slave    req,
  output logic                uart_tx,
  output logic                busy,
  output logic                grant_id
);
  logic [2:0] state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic       tx_q, tx_d;
  logic       tick, idle, win, accept, baud_clr;
  logic [7:0] win_data;

  // Counter held at zero in IDLE so every START begins a full bit period.
  assign baud_clr = (state_q == ST_IDLE);

  uart_baud_tick #(.DIV(DIV), .CNT_W(CNT_W)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (baud_clr),
    .tick  (tick)
  );

  // A tie goes to whoever did not own the previous frame.
  assign idle     = (state_q == ST_IDLE) && !reset;
  assign win      = (req.req0_valid && req.req1_valid) ? ~last_q : req.req1_valid;
  assign win_data = win ? req.req1_data : req.req0_data;
  assign req.req0_ready = idle && req.req0_valid && !win;
  assign req.req1_ready = idle && req.req1_valid &&  win;
  assign accept   = req.req0_ready || req.req1_ready;

`ifdef UART_ARB_PARITY_EN
  logic par_q, par_d;
  always_comb begin
    par_d = par_q;
    if (accept) par_d = even_parity(win_data);
  end
  always_ff @(posedge clk) begin
    if (reset) par_q <= 1'b0;
    else       par_q <= par_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    grant_d   = grant_q;
    last_d    = last_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d = ST_START;
        shift_d = win_data;
        grant_d = win;
        last_d  = win;
      end
      ST_START: if (tick) begin
        state_d   = ST_DATA;
        bit_idx_d = '0;
      end
      ST_DATA: if (tick) begin
        shift_d   = shift_q >> 1;
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_ARB_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_ARB_PARITY_EN
      ST_PARITY: if (tick) state_d = ST_STOP;
`endif
      ST_STOP: if (tick) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level follows the state one cycle late (registered output).
  always_comb begin
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
`ifdef UART_ARB_PARITY_EN
      ST_PARITY: tx_d = par_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      tx_q      <= tx_d;
    end
  end

  assign uart_tx  = tx_q;
  assign busy     = (state_q != ST_IDLE);
  assign grant_id = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: line decoder plus round-robin order model.
module tb_uart_tx_arbiter;
  localparam int DIV = 4;
`ifdef UART_ARB_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] b;
    int         t;
    logic       gid;
    logic       ok;
    logic       par;
  } frm_t;

  logic clk = 0, reset = 1;
  logic uart_tx, busy, grant_id;
  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.DIV(DIV), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req(bus), .uart_tx(uart_tx), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0, fails = 0;
  bit m_last = 1;
  frm_t rxq[$];

  // Line decoder: frames start at a falling edge, each bit sampled mid-period
  // and required to hold one level for the whole period.
  logic        prev_tx = 1;
  bit          m_act = 0, m_stable;
  int          m_c, m_start;
  logic        m_lvl, m_gid;
  logic [11:0] m_bits;
  always @(negedge clk) begin
    if (reset) m_act = 0;
    else if (!m_act) begin
      if (prev_tx === 1'b1 && uart_tx === 1'b0) begin
        m_act = 1; m_c = 0; m_start = cyc; m_stable = 1; m_lvl = 0;
        m_bits = '0; m_gid = grant_id;
      end
    end else begin
      m_c++;
      if (m_c % DIV == 0) m_lvl = uart_tx;
      else if (uart_tx !== m_lvl) m_stable = 0;
      if (m_c % DIV == DIV / 2) m_bits[m_c / DIV] = uart_tx;
      if (m_c == FRAME * DIV - 1) begin
        frm_t f;
        f.b = m_bits[8:1]; f.t = m_start; f.gid = m_gid; f.par = m_bits[9];
        f.ok = m_stable && (m_bits[0] === 1'b0) && (m_bits[FRAME-1] === 1'b1);
        rxq.push_back(f);
        m_act = 0;
      end
    end
    prev_tx = uart_tx;
  end

  task automatic do_reset();
    reset = 1;
    bus.req0_valid = 0; bus.req1_valid = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    m_last = 1;
  endtask

  // Both requesters present their queues; req1 from t=0, req0 from t=d0
  // (d0 < one frame). The expected order is derived from the round-robin rule.
  task automatic run_stream(input string nm, input bq_t b0, input bq_t b1, input int d0);
    bq_t eb; bit eg[$];
    int n0 = b0.size(), n1 = b1.size(), tot, i0 = 0, i1 = 0, h0n = 0, h1n = 0, bz = 0;
    bit last = m_last, first = 1, a0, a1, w, both = 0, rb = 0, h0, h1;
    tot = n0 + n1;
    while (i0 < n0 || i1 < n1) begin
      a0 = (i0 < n0) && (!first || d0 == 0);
      a1 = (i1 < n1);
      w = (a0 && a1) ? !last : a1;
      if (w) begin eb.push_back(b1[i1]); i1++; end
      else   begin eb.push_back(b0[i0]); i0++; end
      eg.push_back(w); last = w; first = 0;
    end
    m_last = last;
    i0 = 0; i1 = 0;
    rxq.delete();
    for (int t = 0; t < tot * (FRAME * DIV + 1) + d0 + 40; t++) begin
      bus.req0_valid = (i0 < n0) && (t >= d0);
      bus.req0_data  = (i0 < n0) ? b0[i0] : 8'h00;
      bus.req1_valid = (i1 < n1);
      bus.req1_data  = (i1 < n1) ? b1[i1] : 8'h00;
      @(negedge clk);
      h0 = bus.req0_valid && bus.req0_ready;
      h1 = bus.req1_valid && bus.req1_ready;
      if (bus.req0_ready && bus.req1_ready) both = 1;
      if (busy && (bus.req0_ready || bus.req1_ready)) rb = 1;
      if (busy) bz++;
      @(posedge clk); #1;
      if (h0) begin i0++; h0n++; end
      if (h1) begin i1++; h1n++; end
      if (rxq.size() >= tot) break;
    end
    bus.req0_valid = 0; bus.req1_valid = 0;

    tests_run++;
    if (rxq.size() !== tot) begin fails++; $display("FAIL %s frame_count: got %0d want %0d", nm, rxq.size(), tot); end
    for (int i = 0; i < tot && i < rxq.size(); i++) begin
      tests_run++;
      if (rxq[i].b !== eb[i]) begin fails++; $display("FAIL %s frame%0d byte: got %h want %h", nm, i, rxq[i].b, eb[i]); end
      tests_run++;
      if (rxq[i].gid !== eg[i]) begin fails++; $display("FAIL %s frame%0d grant_id: got %0d want %0d", nm, i, rxq[i].gid, eg[i]); end
      tests_run++;
      if (rxq[i].ok !== 1'b1) begin fails++; $display("FAIL %s frame%0d framing: got %0d want 1", nm, i, rxq[i].ok); end
`ifdef UART_ARB_PARITY_EN
      tests_run++;
      if (rxq[i].par !== ^eb[i]) begin fails++; $display("FAIL %s frame%0d parity: got %0d want %0d", nm, i, rxq[i].par, ^eb[i]); end
`endif
      if (i > 0) begin
        tests_run++;
        if (rxq[i].t - rxq[i-1].t !== FRAME * DIV + 1) begin
          fails++; $display("FAIL %s frame%0d spacing: got %0d want %0d", nm, i, rxq[i].t - rxq[i-1].t, FRAME * DIV + 1);
        end
      end
    end
    tests_run++;
    if (h0n !== n0 || h1n !== n1) begin fails++; $display("FAIL %s handshakes: got %0d/%0d want %0d/%0d", nm, h0n, h1n, n0, n1); end
    tests_run++;
    if (both !== 0) begin fails++; $display("FAIL %s both_ready: got 1 want 0", nm); end
    tests_run++;
    if (rb !== 0) begin fails++; $display("FAIL %s ready_while_busy: got 1 want 0", nm); end
    tests_run++;
    if (bz !== tot * FRAME * DIV) begin fails++; $display("FAIL %s busy_cycles: got %0d want %0d", nm, bz, tot * FRAME * DIV); end
  endtask

  task automatic test_reset();
    reset = 1; bus.req0_valid = 1; bus.req0_data = 8'h3C; bus.req1_valid = 0; bus.req1_data = 0;
    repeat (2) @(posedge clk); #1;
    tests_run++; if (uart_tx !== 1'b1) begin fails++; $display("FAIL reset uart_tx: got %b want 1", uart_tx); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b want 0", busy); end
    tests_run++; if (bus.req0_ready !== 1'b0) begin fails++; $display("FAIL reset req0_ready: got %b want 0", bus.req0_ready); end
    tests_run++; if (bus.req1_ready !== 1'b0) begin fails++; $display("FAIL reset req1_ready: got %b want 0", bus.req1_ready); end
    tests_run++; if (grant_id !== 1'b0) begin fails++; $display("FAIL reset grant_id: got %b want 0", grant_id); end
    bus.req0_valid = 0;
    reset = 0; m_last = 1;
  endtask

  task automatic test_single();
    bq_t q0, q1;
    q0.push_back(8'h55);
    run_stream("single_55", q0, q1, 0);
  endtask

  task automatic test_tie();
    bq_t q0, q1;
    do_reset();
    q0.push_back(8'hA0); q1.push_back(8'h0F);
    run_stream("tie", q0, q1, 0);
  endtask

  task automatic test_back_to_back();
    bq_t q0, q1;
    for (int i = 0; i < 2; i++) begin q0.push_back(8'($urandom)); q1.push_back(8'($urandom)); end
    run_stream("back_to_back", q0, q1, 0);
  endtask

  task automatic test_mid_frame();
    bq_t q0, q1;
    q1.push_back(8'hFF); q0.push_back(8'($urandom));
    run_stream("mid_frame", q0, q1, 15);
  endtask

  task automatic test_reset_mid();
    logic [7:0] b = 8'($urandom);
    bit ok = 0, served = 0;
    int rel;
    do_reset();
    bus.req1_valid = 1; bus.req1_data = b;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk); if (bus.req1_ready) ok = 1;
      @(posedge clk); #1;
    end
    tests_run++; if (!ok) begin fails++; $display("FAIL rst_mid first_accept: got 0 want 1"); end
    repeat (14) @(posedge clk); #1;
    tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_mid busy_before: got %b want 1", busy); end
    reset = 1;
    @(posedge clk); #1;
    tests_run++; if (uart_tx !== 1'b1) begin fails++; $display("FAIL rst_mid uart_tx: got %b want 1", uart_tx); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid busy: got %b want 0", busy); end
    tests_run++; if (bus.req1_ready !== 1'b0) begin fails++; $display("FAIL rst_mid ready_in_reset: got %b want 0", bus.req1_ready); end
    reset = 0; m_last = 1; rel = cyc;
    rxq.delete();
    for (int t = 0; t < 3 * FRAME * DIV && rxq.size() == 0; t++) begin
      @(negedge clk); if (bus.req1_ready) served = 1;
      @(posedge clk); #1;
      if (served) bus.req1_valid = 0;
    end
    bus.req1_valid = 0;
    m_last = 1;
    tests_run++;
    if (rxq.size() !== 1) begin fails++; $display("FAIL rst_mid frame_count: got %0d want 1", rxq.size()); end
    else begin
      tests_run++; if (rxq[0].b !== b) begin fails++; $display("FAIL rst_mid byte: got %h want %h", rxq[0].b, b); end
      tests_run++; if (rxq[0].ok !== 1'b1 || rxq[0].gid !== 1'b1) begin fails++; $display("FAIL rst_mid frame: got ok=%0d gid=%0d want 1/1", rxq[0].ok, rxq[0].gid); end
      tests_run++; if (rxq[0].t <= rel) begin fails++; $display("FAIL rst_mid start_time: got %0d want >%0d", rxq[0].t, rel); end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      bq_t q0, q1;
      int n0 = $urandom_range(0, 3), n1 = $urandom_range(0, 3), d0;
      if (n0 + n1 == 0) n1 = 1;
      for (int i = 0; i < n0; i++) q0.push_back(8'($urandom));
      for (int i = 0; i < n1; i++) q1.push_back(8'($urandom));
      d0 = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, FRAME * DIV - 1);
      run_stream($sformatf("random%0d", r), q0, q1, d0);
    end
  endtask

`ifdef UART_ARB_PARITY_EN
  task automatic test_parity();
    bq_t q0, q1;
    do_reset();
    q0.push_back(8'h07); q1.push_back(8'h03);
    run_stream("parity", q0, q1, 0);
    tests_run++;
    if (rxq.size() < 2 || rxq[0].par !== 1'b1 || rxq[1].par !== 1'b0) begin
      fails++; $display("FAIL parity_bits: got %0d frames want bits 1,0", rxq.size());
    end
  endtask
`endif

  initial begin
    bus.req0_valid = 0; bus.req0_data = 0; bus.req1_valid = 0; bus.req1_data = 0;
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_mid_frame();
    test_reset_mid();
    test_random();
`ifdef UART_ARB_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
